// File: rtl/pipe_ctrl_if.sv
// Pipeline sequencer bus: hazard/event requests in, per-stage enables and
// status out. The performance-counter signals exist only when
// PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if
`ifdef PIPE_CTRL_PERF_EN
  #(parameter int CNT_W = 32)
`endif
  ;

  // Requests from decode / execute / outside world
  logic jump_taken;
  logic load_use;
  logic halt_req;
  logic pause_req;

  // Stage enables and status
  logic       fetch_en;
  logic       decode_en;
  logic       exec_en;
  logic       write_en;
  logic       flush;
  logic       stall;
  logic       halted;
  logic [2:0] state_o;

`ifdef PIPE_CTRL_PERF_EN
  logic             perf_clr;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  // Sequencer side
  modport master (
    input  jump_taken, load_use, halt_req, pause_req,
`ifdef PIPE_CTRL_PERF_EN
    input  perf_clr,
    output cycle_cnt, stall_cnt, flush_cnt,
`endif
    output fetch_en, decode_en, exec_en, write_en,
    output flush, stall, halted, state_o
  );

  // Pipeline-stage side
  modport slave (
    output jump_taken, load_use, halt_req, pause_req,
`ifdef PIPE_CTRL_PERF_EN
    output perf_clr,
    input  cycle_cnt, stall_cnt, flush_cnt,
`endif
    input  fetch_en, decode_en, exec_en, write_en,
    input  flush, stall, halted, state_o
  );

endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer of the 4-stage RV32I pipeline
// (fetch / decode / execute / write). Handles warm-up, jump flush,
// single-cycle load-use stall, external pause and halt.
// All outputs are registered and decoded from the next state, so no
// input reaches an enable combinationally.
// Optional feature macro: PIPE_CTRL_PERF_EN (saturating cycle / stall /
// flush counters with synchronous clear). Default build has no counters.
module pipe_ctrl
`ifdef PIPE_CTRL_PERF_EN
  #(parameter int CNT_W = 32)
`endif
  (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    W1         = 3'd1,
    W2         = 3'd2,
    W3         = 3'd3,
    RUN        = 3'd4,
    STALL_LOAD = 3'd5,
    PAUSE      = 3'd6,
    HALT       = 3'd7
  } state_t;

  state_t state;
  state_t saved_state;
  state_t state_nxt;
  state_t saved_nxt;
  logic   flush_nxt;

  // Stage enables per state, packed {fetch, decode, exec, write}
  function automatic logic [3:0] stage_enables(input state_t s);
    logic [3:0] en;
    case (s)
      W1:         en = 4'b1000;
      W2:         en = 4'b1100;
      W3:         en = 4'b1110;
      RUN:        en = 4'b1111;
      STALL_LOAD: en = 4'b0011;
      default:    en = 4'b0000;
    endcase
    return en;
  endfunction

  // Current-state stage activity used by the request qualifiers
  logic [3:0] cur_en;
  assign cur_en = stage_enables(state);

  // Next-state selection; earlier rules take precedence over later ones
  always_comb begin
    state_nxt = state;
    saved_nxt = saved_state;
    flush_nxt = 1'b0;
    if (state == HALT) begin
      state_nxt = HALT;
    end else if (bus.halt_req && cur_en[1]) begin
      state_nxt = HALT;
    end else if (bus.jump_taken && cur_en[1]) begin
      // Younger instructions are discarded; refill from scratch
      state_nxt = INIT;
      flush_nxt = 1'b1;
    end else if (bus.load_use && cur_en[2]) begin
      state_nxt = STALL_LOAD;
    end else if (state == PAUSE) begin
      state_nxt = bus.pause_req ? PAUSE : saved_state;
    end else if (bus.pause_req) begin
      // Remember where to resume, including a pending STALL_LOAD cycle
      state_nxt = PAUSE;
      saved_nxt = state;
    end else begin
      case (state)
        INIT:       state_nxt = W1;
        W1:         state_nxt = W2;
        W2:         state_nxt = W3;
        W3:         state_nxt = RUN;
        STALL_LOAD: state_nxt = RUN;
        default:    state_nxt = RUN;
      endcase
    end
  end

  // State register with registered Moore outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= INIT;
      saved_state   <= INIT;
      bus.fetch_en  <= 1'b0;
      bus.decode_en <= 1'b0;
      bus.exec_en   <= 1'b0;
      bus.write_en  <= 1'b0;
      bus.flush     <= 1'b0;
      bus.stall     <= 1'b0;
      bus.halted    <= 1'b0;
    end else begin
      state       <= state_nxt;
      saved_state <= saved_nxt;
      {bus.fetch_en, bus.decode_en, bus.exec_en, bus.write_en} <= stage_enables(state_nxt);
      bus.flush   <= flush_nxt;
      bus.stall   <= (state_nxt == STALL_LOAD) || (state_nxt == PAUSE);
      bus.halted  <= (state_nxt == HALT);
    end
  end

  assign bus.state_o = state;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Event counters; a clear overrides any increment in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.perf_clr) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != HALT) cycle_cnt <= sat_inc(cycle_cnt);
      if (bus.stall)     stall_cnt <= sat_inc(stall_cnt);
      if (bus.flush)     flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.cycle_cnt = cycle_cnt;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against an occupancy-based model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
  pipe_ctrl_if #(.CNT_W(CNT_W)) bus();
  pipe_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  pipe_ctrl_if bus();
  pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         j, l, h, p;
    int         st;
    logic [3:0] en;
    bit         fl;
  } vec_t;
  vec_t tbl[$];

  // Model: number of filled stages plus an operating mode
  // mode 0 = flowing, 1 = load stall, 2 = paused, 3 = halted
  int m_fill, m_mode, s_fill, s_mode;
  bit m_flush;
`ifdef PIPE_CTRL_PERF_EN
  int m_cyc, m_stl, m_fls;
`endif

  function automatic int m_code();
    case (m_mode)
      0: return m_fill;
      1: return 5;
      2: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [3:0] m_en();
    logic [3:0] t;
    t = 4'b1111;
    if (m_mode == 0) t = t << (4 - m_fill);
    else if (m_mode == 1) t = 4'b0011;
    else t = 4'b0000;
    return t;
  endfunction

  task automatic model_reset();
    m_fill = 0; m_mode = 0; s_fill = 0; s_mode = 0; m_flush = 0;
`ifdef PIPE_CTRL_PERF_EN
    m_cyc = 0; m_stl = 0; m_fls = 0;
`endif
  endtask

  task automatic model_step(input bit j, input bit l, input bit h, input bit p, input bit clr);
    bit ex_act, dec_act, nf;
    ex_act  = (m_mode == 0 && m_fill >= 3) || (m_mode == 1);
    dec_act = (m_mode == 0 && m_fill >= 2);
    nf = 0;
`ifdef PIPE_CTRL_PERF_EN
    if (clr) begin
      m_cyc = 0; m_stl = 0; m_fls = 0;
    end else begin
      if (m_mode != 3 && m_cyc < MAXC) m_cyc++;
      if ((m_mode == 1 || m_mode == 2) && m_stl < MAXC) m_stl++;
      if (m_flush && m_fls < MAXC) m_fls++;
    end
`else
    if (clr) nf = 0;
`endif
    if (m_mode == 3) begin
    end else if (h && ex_act) begin
      m_mode = 3;
    end else if (j && ex_act) begin
      m_mode = 0; m_fill = 0; nf = 1;
    end else if (l && dec_act) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (!p) begin m_mode = s_mode; m_fill = s_fill; end
    end else if (p) begin
      s_mode = m_mode; s_fill = m_fill; m_mode = 2;
    end else if (m_mode == 1) begin
      m_mode = 0; m_fill = 4;
    end else if (m_fill < 4) begin
      m_fill++;
    end
    m_flush = nf;
  endtask

  task automatic drive(input bit j, input bit l, input bit h, input bit p);
    bus.jump_taken = j;
    bus.load_use   = l;
    bus.halt_req   = h;
    bus.pause_req  = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int st, input logic [3:0] en, input bit fl);
    logic [3:0] a_en;
    bit e_stall, e_halt;
    a_en    = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.write_en};
    e_stall = (st == 5) || (st == 6);
    e_halt  = (st == 7);
    checks++;
    if (int'(bus.state_o) != st || a_en !== en || bus.flush !== fl ||
        bus.stall !== e_stall || bus.halted !== e_halt) begin
      errors++;
      $display("FAIL %s: got state=%0d en=%b flush=%b stall=%b halted=%b, expected state=%0d en=%b flush=%b stall=%b halted=%b",
               nm, bus.state_o, a_en, bus.flush, bus.stall, bus.halted, st, en, fl, e_stall, e_halt);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic chk_cnt(input string nm, input int cy, input int sc, input int fc);
    checks++;
    if (int'(bus.cycle_cnt) != cy || int'(bus.stall_cnt) != sc || int'(bus.flush_cnt) != fc) begin
      errors++;
      $display("FAIL %s: got cycle=%0d stall=%0d flush=%0d, expected cycle=%0d stall=%0d flush=%0d",
               nm, bus.cycle_cnt, bus.stall_cnt, bus.flush_cnt, cy, sc, fc);
    end
  endtask
`endif

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    bus.perf_clr = 1'b0;
`endif
    #2;
    chk("async_reset", 0, 4'b0000, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk_cnt("reset_counters", 0, 0, 0);
`endif
    tick();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic add(input bit j, input bit l, input bit h, input bit p,
                     input int st, input logic [3:0] en, input bit fl);
    vec_t v;
    v.j = j; v.l = l; v.h = h; v.p = p; v.st = st; v.en = en; v.fl = fl;
    tbl.push_back(v);
  endtask

  initial begin
    bit pr, j, l, h, c;
    int halt_cycles;

    drive(0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    bus.perf_clr = 1'b0;
`endif
    model_reset();

    // warm-up after reset
    add(0,0,0,0, 1, 4'b1000, 0);
    add(0,0,0,0, 2, 4'b1100, 0);
    add(0,0,0,0, 3, 4'b1110, 0);
    add(0,0,0,0, 4, 4'b1111, 0);
    // single load-use pulse, then held for two cycles
    add(0,1,0,0, 5, 4'b0011, 0);
    add(0,0,0,0, 4, 4'b1111, 0);
    add(0,1,0,0, 5, 4'b0011, 0);
    add(0,1,0,0, 4, 4'b1111, 0);
    add(0,0,0,0, 4, 4'b1111, 0);
    // jump with load_use: jump wins, one flush pulse, refill
    add(1,1,0,0, 0, 4'b0000, 1);
    add(0,0,0,0, 1, 4'b1000, 0);
    add(0,0,0,0, 2, 4'b1100, 0);
    add(0,0,0,0, 3, 4'b1110, 0);
    add(0,0,0,0, 4, 4'b1111, 0);
    // pause during STALL_LOAD resumes into STALL_LOAD
    add(0,1,0,0, 5, 4'b0011, 0);
    for (int i = 0; i < 5; i++) add(0,0,0,1, 6, 4'b0000, 0);
    add(0,0,0,0, 5, 4'b0011, 0);
    add(0,0,0,0, 4, 4'b1111, 0);
    // pause together with jump: INIT first, pause saves INIT; jump in PAUSE ignored
    add(1,0,0,1, 0, 4'b0000, 1);
    add(0,0,0,1, 6, 4'b0000, 0);
    add(1,0,1,1, 6, 4'b0000, 0);
    add(0,0,0,0, 0, 4'b0000, 0);
    add(0,0,0,0, 1, 4'b1000, 0);
    add(0,0,0,0, 2, 4'b1100, 0);
    add(0,0,0,0, 3, 4'b1110, 0);
    add(0,0,0,0, 4, 4'b1111, 0);
    // halt is sticky
    add(0,0,1,0, 7, 4'b0000, 0);
    add(1,0,0,1, 7, 4'b0000, 0);
    add(0,0,0,0, 7, 4'b0000, 0);

    // reset held low across edges
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 0, 4'b0000, 0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].j, tbl[i].l, tbl[i].h, tbl[i].p);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].en, tbl[i].fl);
    end

    // reset exits HALT; halt_req ignored until execute is active
    apply_reset();
    chk("halt_reset_exit", 0, 4'b0000, 0);
    drive(0, 0, 1, 0);
    tick(); chk("halt_ign_init", 1, 4'b1000, 0);
    tick(); chk("halt_ign_w1",   2, 4'b1100, 0);
    tick(); chk("halt_ign_w2",   3, 4'b1110, 0);
    tick(); chk("halt_in_w3",    7, 4'b0000, 0);
    drive(0, 0, 0, 0);

    // randomized traffic against the model
    apply_reset();
    pr = 0;
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((m_mode == 3 && halt_cycles > 8) || $urandom_range(0, 599) == 0) begin
        apply_reset();
        halt_cycles = 0;
        continue;
      end
      j = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) pr = !pr;
      c = ($urandom_range(0, 39) == 0);
      drive(j, l, h, pr);
`ifdef PIPE_CTRL_PERF_EN
      bus.perf_clr = c;
`endif
      model_step(j, l, h, pr, c);
      tick();
      chk($sformatf("rand%0d", i), m_code(), m_en(), m_flush);
`ifdef PIPE_CTRL_PERF_EN
      chk_cnt($sformatf("rand_cnt%0d", i), m_cyc, m_stl, m_fls);
`endif
      if (m_mode == 3) halt_cycles++;
    end
    drive(0, 0, 0, 0);

`ifdef PIPE_CTRL_PERF_EN
    // saturation, clear, flush counting
    bus.perf_clr = 1'b0;
    apply_reset();
    repeat (20) tick();
    chk_cnt("cycle_saturate", 15, 0, 0);
    bus.perf_clr = 1'b1;
    tick();
    bus.perf_clr = 1'b0;
    chk_cnt("perf_clr", 0, 0, 0);
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0); repeat (4) tick();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    chk_cnt("two_flushes", 7, 0, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
